// File: rtl/csa_acc_pkg.sv
// ---------------------------------------------------------------------------
// csa_acc_pkg
//   Shared types and helpers for the carry-save accumulator.
//   - csa_acc_state_t : accumulator control states
//   - nch()           : number of RES_CHUNK-wide chunks covering ACC_LEN bits
//   - cnt_width()     : width of a counter that indexes those chunks
// ---------------------------------------------------------------------------
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        FLUSH   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } csa_acc_state_t;

    function automatic int unsigned nch(input int unsigned acc_len, input int unsigned chunk);
        return (acc_len + chunk - 1) / chunk;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width for the default configuration (ACC_LEN=27, RES_CHUNK=8)
    localparam int unsigned CSA_ACC_DEF_NCH = nch(27, 8);
    localparam int unsigned CSA_ACC_CNT_W   = cnt_width(CSA_ACC_DEF_NCH);

endpackage

// File: rtl/csa_accumulator_tree.sv
// ---------------------------------------------------------------------------
// csa_tree
//   Combinational N:2 carry-save compressor built from rows of 3:2
//   full-adder cells. All arithmetic is modulo 2^W.
//   Ports:
//     i_ops   in  N*W  operand k = i_ops[k*W +: W]
//     o_sum   out W    sum vector
//     o_carry out W    carry vector, already shifted into weight position
//   Sum of operands == o_sum + o_carry (mod 2^W).
// ---------------------------------------------------------------------------
module csa_tree #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 3
) (
    input  logic [N*W-1:0] i_ops,
    output logic [W-1:0]   o_sum,
    output logic [W-1:0]   o_carry
);

    generate
        if (N == 1) begin : g_one
            assign o_sum   = i_ops[W-1:0];
            assign o_carry = '0;
        end else if (N == 2) begin : g_two
            assign o_sum   = i_ops[W-1:0];
            assign o_carry = i_ops[2*W-1:W];
        end else begin : g_rows
            logic [W-1:0] w_s [N-1];
            logic [W-1:0] w_c [N-1];

            assign w_s[0] = i_ops[W-1:0];
            assign w_c[0] = i_ops[2*W-1:W];

            // Each row folds one more operand into the running sum/carry pair;
            // the carry shift drops the top bit, keeping everything mod 2^W.
            for (genvar k = 1; k < N - 1; k++) begin : g_row
                logic [W-1:0] w_x;
                assign w_x    = i_ops[(k+1)*W +: W];
                assign w_s[k] = w_s[k-1] ^ w_c[k-1] ^ w_x;
                assign w_c[k] = ((w_s[k-1] & w_c[k-1]) | (w_s[k-1] & w_x) | (w_c[k-1] & w_x)) << 1;
            end

            assign o_sum   = w_s[N-2];
            assign o_carry = w_c[N-2];
        end
    endgenerate

endmodule

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//   Streaming multi-operand accumulator. Each accepted beat adds NUM_IN words
//   into a redundant sum/carry accumulator; after the last beat a chunked
//   carry-propagate pass resolves the result, which is then held on a
//   valid/ready output. Result is modulo 2^ACC_LEN.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     in_valid   in   beat present
//     in_ready   out  beat accepted when in_valid & in_ready
//     in_data    in   NUM_IN words, word j = in_data[j*BIT_LEN +: BIT_LEN]
//     in_last    in   final beat of the accumulation
//     out_valid  out  resolved result available
//     out_ready  in   result consumed when out_valid & out_ready
//     out_sum    out  resolved sum
//   Build option:
//     CSA_ACC_PIPE_EN  register stage between input reduction and 4:2 merge,
//                      adds a one-cycle FLUSH state before RESOLVE.
// ---------------------------------------------------------------------------
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned BIT_LEN   = 19,
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned ACC_LEN   = BIT_LEN + 8,
    parameter int unsigned RES_CHUNK = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*BIT_LEN-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_LEN-1:0]        out_sum
);

    localparam int unsigned NCH   = nch(ACC_LEN, RES_CHUNK);
    localparam int unsigned CNT_W = cnt_width(NCH);

    csa_acc_state_t r_state;
    csa_acc_state_t w_next;

    logic [ACC_LEN-1:0]        r_acc_s;
    logic [ACC_LEN-1:0]        r_acc_c;
    logic [ACC_LEN-1:0]        r_out;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_cy;

    logic [NUM_IN*ACC_LEN-1:0] w_ops;
    logic [ACC_LEN-1:0]        w_tree_s;
    logic [ACC_LEN-1:0]        w_tree_c;
    logic [ACC_LEN-1:0]        w_m_s;
    logic [ACC_LEN-1:0]        w_m_c;
    logic [ACC_LEN-1:0]        w_acc_c_sh;
    logic [ACC_LEN-1:0]        w_r1_s;
    logic [ACC_LEN-1:0]        w_r1_c;
    logic [ACC_LEN-1:0]        w_new_s;
    logic [ACC_LEN-1:0]        w_new_c;
    logic                      w_accept;
    logic                      w_merge;
    logic                      w_last_chunk;
    logic [31:0]               w_sh;
    logic [RES_CHUNK-1:0]      w_cs;
    logic [RES_CHUNK-1:0]      w_cc;
    logic [RES_CHUNK:0]        w_chunk;
    logic [ACC_LEN-1:0]        w_mask;
    logic [ACC_LEN-1:0]        w_ins;

    // ---------------- input reduction ----------------
    always_comb begin
        w_ops = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            w_ops[j*ACC_LEN +: ACC_LEN] = ACC_LEN'(in_data[j*BIT_LEN +: BIT_LEN]);
        end
    end

    csa_tree #(
        .W (ACC_LEN),
        .N (NUM_IN)
    ) u_in_tree (
        .i_ops   (w_ops),
        .o_sum   (w_tree_s),
        .o_carry (w_tree_c)
    );

    assign w_accept = in_valid & in_ready;

`ifdef CSA_ACC_PIPE_EN
    logic [ACC_LEN-1:0] r_pipe_s;
    logic [ACC_LEN-1:0] r_pipe_c;
    logic               r_pipe_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_s <= '0;
            r_pipe_c <= '0;
            r_pipe_v <= 1'b0;
        end else begin
            r_pipe_v <= w_accept;
            if (w_accept) begin
                r_pipe_s <= w_tree_s;
                r_pipe_c <= w_tree_c;
            end
        end
    end

    assign w_m_s   = r_pipe_s;
    assign w_m_c   = r_pipe_c;
    assign w_merge = r_pipe_v;
`else
    assign w_m_s   = w_tree_s;
    assign w_m_c   = w_tree_c;
    assign w_merge = w_accept;
`endif

    // ---------------- 4:2 merge into the accumulator ----------------
    // r_acc_c holds carries at their generating bit; the <<1 here drops the
    // MSB, which is what makes the accumulation wrap mod 2^ACC_LEN.
    assign w_acc_c_sh = r_acc_c << 1;
    assign w_r1_s     = w_m_s ^ w_m_c ^ r_acc_s;
    assign w_r1_c     = ((w_m_s & w_m_c) | (w_m_s & r_acc_s) | (w_m_c & r_acc_s)) << 1;
    assign w_new_s    = w_r1_s ^ w_r1_c ^ w_acc_c_sh;
    assign w_new_c    = (w_r1_s & w_r1_c) | (w_r1_s & w_acc_c_sh) | (w_r1_c & w_acc_c_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
        end else if (r_state == OUT && out_ready) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
        end else if (w_merge) begin
            r_acc_s <= w_new_s;
            r_acc_c <= w_new_c;
        end
    end

    // ---------------- chunked carry-propagate ----------------
    assign w_sh         = 32'(r_cnt) * RES_CHUNK;
    assign w_last_chunk = (r_cnt == CNT_W'(NCH - 1));
    assign w_cs         = RES_CHUNK'(r_acc_s >> w_sh);
    assign w_cc         = RES_CHUNK'(w_acc_c_sh >> w_sh);
    assign w_chunk      = {1'b0, w_cs} + {1'b0, w_cc} + (RES_CHUNK+1)'(r_cy);
    // Masking to ACC_LEN bits trims the partial top chunk; its carry-out is
    // never used because the counter wraps on the last chunk.
    assign w_mask       = ACC_LEN'({RES_CHUNK{1'b1}}) << w_sh;
    assign w_ins        = ACC_LEN'(w_chunk[RES_CHUNK-1:0]) << w_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_cy  <= 1'b0;
            r_out <= '0;
        end else if (r_state == RESOLVE) begin
            r_out <= (r_out & ~w_mask) | (w_ins & w_mask);
            if (w_last_chunk) begin
                r_cnt <= '0;
                r_cy  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_cy  <= w_chunk[RES_CHUNK];
            end
        end
    end

    assign out_sum = r_out;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
`ifdef CSA_ACC_PIPE_EN
                    w_next = FLUSH;
`else
                    w_next = RESOLVE;
`endif
                end
            end
            FLUSH: begin
                w_next = RESOLVE;
            end
            RESOLVE: begin
                if (w_last_chunk) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ACCUM;
                end
            end
            default: begin
                w_next = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

    localparam int unsigned BIT_LEN   = 19;
    localparam int unsigned NUM_IN    = 4;
    localparam int unsigned ACC_LEN   = 27;
    localparam int unsigned RES_CHUNK = 8;
`ifdef CSA_ACC_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_IN*BIT_LEN-1:0] in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_LEN-1:0]        out_sum;

    int n_cmp = 0;
    int n_err = 0;

    csa_accumulator #(
        .BIT_LEN   (BIT_LEN),
        .NUM_IN    (NUM_IN),
        .ACC_LEN   (ACC_LEN),
        .RES_CHUNK (RES_CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat; the caller guarantees the DUT is in ACCUM.
    task automatic send_beat(input logic [18:0] a, input logic [18:0] b,
                             input logic [18:0] c, input logic [18:0] d, input logic last);
        in_data  = {d, c, b, a};
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (out_sum !== 27'd0) begin n_err++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        int e;
        send_beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1);
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd10) begin n_err++; $display("FAIL single_sum: got %0d expected 10", out_sum); end
        handshake();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_back: got %0b expected 1", in_ready); end
    endtask

    task automatic test_three_beats();
        int e;
        send_beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0);
        send_beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0);
        send_beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b1);
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL three_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd6291444) begin n_err++; $display("FAIL three_sum: got %0d expected 6291444", out_sum); end
        handshake();
    endtask

    task automatic test_wrap();
        int e;
        for (int i = 0; i < 65; i++) begin
            send_beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, (i == 64));
        end
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL wrap_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd2096892) begin n_err++; $display("FAIL wrap_sum: got %0d expected 2096892", out_sum); end
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        send_beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1);
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", e, LAT); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b expected 1", i, out_valid); end
            n_cmp++; if (out_sum !== 27'd10) begin n_err++; $display("FAIL bp_sum[%0d]: got %0d expected 10", i, out_sum); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", i, in_ready); end
            @(posedge clk);
            #1;
        end
        handshake();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %0b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after: got %0b expected 0", out_valid); end
    endtask

    task automatic test_hold_during_resolve();
        int e;
        send_beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1);
        // Present the next beat immediately and hold it.
        in_data  = {19'd0, 19'd0, 19'd0, 19'd7};
        in_valid = 1'b1;
        in_last  = 1'b1;
        e = 0;
        while (!out_valid && e < 50) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %0b expected 0", e, in_ready); end
            @(posedge clk);
            #1;
            e++;
        end
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL hold_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd10) begin n_err++; $display("FAIL hold_first_sum: got %0d expected 10", out_sum); end
        handshake();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready_after: got %0b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL hold_second_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd7) begin n_err++; $display("FAIL hold_second_sum: got %0d expected 7", out_sum); end
        handshake();
    endtask

    task automatic test_reset_mid_resolve();
        int e;
        send_beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_busy_in_ready: got %0b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_busy_valid: got %0b expected 0", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %0b expected 1", in_ready); end
        n_cmp++; if (out_sum !== 27'd0) begin n_err++; $display("FAIL mid_rst_sum: got %0d expected 0", out_sum); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_beat(19'd5, 19'd0, 19'd0, 19'd0, 1'b1);
        wait_out(e);
        n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL mid_after_latency: got %0d expected %0d", e, LAT); end
        n_cmp++; if (out_sum !== 27'd5) begin n_err++; $display("FAIL mid_after_sum: got %0d expected 5", out_sum); end
        handshake();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_three_beats();
        test_wrap();
        test_backpressure();
        test_hold_during_resolve();
        test_reset_mid_resolve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
